mo_line_buffer_sequencer: RTL and testbench



---
 rtl/mo_line_buffer_sequencer_if.sv | 41 ++++
 rtl/mo_line_buffer_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mo_line_buffer_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mo_line_buffer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mo_line_buffer_sequencer_if
//  Purpose  : Bundle of the line-sequencer signals shared between the
//             object RAM / vertical-match logic, the sequencer and the
//             horizontal counter block.
//  Ports    : line_start, mo_hit          -> into the sequencer
//             LD1n, LD2n, CL1n, CL2n      -> counter load / clear strobes
//             bank, mo_index, fetch       -> buffer select and object walk
//             wr_en, busy, overrun        -> write gate and line status
//  Revision : 1.0  initial release
// ============================================================================
interface mo_line_buffer_sequencer_if #(
    parameter int IDX_W = 4
);
    logic             line_start;
    logic             mo_hit;
    logic             LD1n;
    logic             LD2n;
    logic             CL1n;
    logic             CL2n;
    logic             bank;
    logic [IDX_W-1:0] mo_index;
    logic             fetch;
    logic             wr_en;
    logic             busy;
    logic             overrun;

    // Sequencer side
    modport master (
        input  line_start, mo_hit,
        output LD1n, LD2n, CL1n, CL2n, bank, mo_index, fetch, wr_en, busy, overrun
    );

    // Surrounding logic side
    modport slave (
        output line_start, mo_hit,
        input  LD1n, LD2n, CL1n, CL2n, bank, mo_index, fetch, wr_en, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/mo_line_buffer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mo_line_buffer_sequencer
//  Purpose  : Per-scanline sequencer for the two motion-object line buffers.
//             Each line the buffers swap roles: the new display buffer has
//             its counter cleared, while the write buffer is loaded with the
//             x-position of every object that hits the line and written for
//             PIX_W consecutive pixels.
//  Ports    : CLK5n  - pixel clock, rising-edge active
//             RESET  - asynchronous, active-high reset
//             bus    - sequencer modport (line_start/mo_hit in; load, clear,
//                      bank, mo_index, fetch, wr_en, busy, overrun out)
//  Revision : 1.0  initial release
// ============================================================================
module mo_line_buffer_sequencer #(
    parameter int NUM_OBJS = 16,
    parameter int IDX_W    = 4,
    parameter int PIX_W    = 8
) (
    input  wire logic                    CLK5n,
    input  wire logic                    RESET,
    mo_line_buffer_sequencer_if.master   bus
);

    localparam int               CNT_W    = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJS - 1);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CHECK = 3'd2,
        S_LOAD  = 3'd3,
        S_DRAW  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           state_q;
    logic             bank_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fetch_q;
    logic             ld1n_q;
    logic             ld2n_q;
    logic             cl1n_q;
    logic             cl2n_q;
    logic             wr_en_q;
    logic             busy_q;
    logic             overrun_q;

    always_ff @(posedge CLK5n or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            bank_q    <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            fetch_q   <= 1'b0;
            ld1n_q    <= 1'b1;
            ld2n_q    <= 1'b1;
            cl1n_q    <= 1'b1;
            cl2n_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // Strobes are single-cycle; they fall back to inactive unless
            // re-asserted below.
            fetch_q   <= 1'b0;
            ld1n_q    <= 1'b1;
            ld2n_q    <= 1'b1;
            cl1n_q    <= 1'b1;
            cl2n_q    <= 1'b1;
            overrun_q <= 1'b0;

            if (bus.line_start) begin
                // A new line overrides whatever is in flight. DONE counts as
                // finished, so only the working states flag an overrun.
                overrun_q <= (state_q != S_IDLE) && (state_q != S_DONE);
                bank_q    <= ~bank_q;
                // New bank 1 makes buffer 1 the display side, and vice versa.
                if (!bank_q) begin
                    cl1n_q <= 1'b0;
                end else begin
                    cl2n_q <= 1'b0;
                end
                idx_q     <= '0;
                fetch_q   <= 1'b1;
                busy_q    <= 1'b1;
                wr_en_q   <= 1'b0;
                state_q   <= S_FETCH;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_FETCH: begin
                        state_q <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (bus.mo_hit) begin
                            // Load the write buffer's counter with SR[15:8].
                            if (bank_q) begin
                                ld2n_q <= 1'b0;
                            end else begin
                                ld1n_q <= 1'b0;
                            end
                            state_q <= S_LOAD;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                    S_LOAD: begin
                        cnt_q   <= '0;
                        wr_en_q <= 1'b1;
                        state_q <= S_DRAW;
                    end
                    S_DRAW: begin
                        // Counter free-runs the address; only the pixel count
                        // is tracked here, wrap at 256 is the counter's job.
                        if (cnt_q == LAST_PIX) begin
                            wr_en_q <= 1'b0;
                            state_q <= S_NEXT;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_NEXT: begin
                        if (idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            fetch_q <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.LD1n     = ld1n_q;
    assign bus.LD2n     = ld2n_q;
    assign bus.CL1n     = cl1n_q;
    assign bus.CL2n     = cl2n_q;
    assign bus.bank     = bank_q;
    assign bus.mo_index = idx_q;
    assign bus.fetch    = fetch_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mo_line_buffer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mo_line_buffer_sequencer
//  Purpose  : Self-checking bench for mo_line_buffer_sequencer. Each
//             line_start pushes the expected per-cycle outputs of that line
//             into a queue; a monitor pops one entry per clock and compares.
//             The bench also plays the object RAM (mo_hit, SR x-position)
//             and the write-side horizontal counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mo_line_buffer_sequencer;

    localparam int NUM_OBJS = 16;
    localparam int IDX_W    = 4;
    localparam int PIX_W    = 8;

    typedef struct packed {
        logic       bank;
        logic [3:0] idx;
        logic       fetch;
        logic       ld1n;
        logic       ld2n;
        logic       cl1n;
        logic       cl2n;
        logic       wr_en;
        logic       busy;
        logic       ovr;
        logic [7:0] addr;
    } exp_t;

    logic CLK5n;
    logic RESET;

    mo_line_buffer_sequencer_if #(.IDX_W(IDX_W)) bus ();

    mo_line_buffer_sequencer #(
        .NUM_OBJS (NUM_OBJS),
        .IDX_W    (IDX_W),
        .PIX_W    (PIX_W)
    ) dut (
        .CLK5n (CLK5n),
        .RESET (RESET),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          checks;
    int          failures;
    logic        model_bank;
    logic        idle_bank;
    logic [3:0]  idle_idx;
    logic [15:0] cur_hits;
    logic [7:0]  cur_x  [NUM_OBJS];
    logic [7:0]  next_x [NUM_OBJS];
    logic [7:0]  sr_x;
    logic [7:0]  wcnt;

    initial begin
        CLK5n = 1'b0;
        forever #5 CLK5n = ~CLK5n;
    end

    // Write-side horizontal counter: loads SR[15:8] on LDn, else free-runs.
    always @(posedge CLK5n) begin
        if (!bus.LD1n || !bus.LD2n) wcnt <= sr_x;
        else                        wcnt <= wcnt + 8'd1;
    end

    // Object RAM / vertical match: answers a fetch in the following cycle.
    initial begin
        logic       f_d;
        logic       h_d;
        logic [7:0] x_d;
        f_d = 1'b0; h_d = 1'b0; x_d = 8'h00;
        sr_x = 8'h00;
        bus.mo_hit = 1'b0;
        forever begin
            @(negedge CLK5n);
            bus.mo_hit = f_d && h_d;
            if (f_d) sr_x = x_d;
            f_d = bus.fetch;
            h_d = cur_hits[bus.mo_index];
            x_d = cur_x[bus.mo_index];
        end
    end

    // Monitor: one comparison per clock, plus the write address on draws.
    initial begin
        exp_t        r;
        logic [12:0] got;
        logic [12:0] want;
        forever begin
            @(negedge CLK5n);
            if (!RESET) begin
                got = {bus.bank, bus.mo_index, bus.fetch, bus.LD1n, bus.LD2n,
                       bus.CL1n, bus.CL2n, bus.wr_en, bus.busy, bus.overrun};
                if (sb.size() > 0) begin
                    r = sb.pop_front();
                    idle_bank = r.bank;
                    idle_idx  = r.idx;
                    want = {r.bank, r.idx, r.fetch, r.ld1n, r.ld2n,
                            r.cl1n, r.cl2n, r.wr_en, r.busy, r.ovr};
                    if (r.wr_en) begin
                        checks++;
                        if (wcnt !== r.addr) begin
                            failures++;
                            $display("FAIL wr_addr t=%0t got=%h want=%h", $time, wcnt, r.addr);
                        end
                    end
                end else begin
                    want = {idle_bank, idle_idx, 1'b0, 4'b1111, 3'b000};
                end
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL cycle t=%0t got=%b want=%b (bank,idx,fetch,LD1n,LD2n,CL1n,CL2n,wr_en,busy,overrun)",
                             $time, got, want);
                end
            end
        end
    end

    // Reference model: expected outputs of one whole line, built from the
    // per-object cycle costs (miss: FETCH CHECK NEXT; hit: adds LOAD + draws).
    task automatic push_line(input logic [15:0] hits, input logic ovr);
        exp_t r;
        model_bank = ~model_bank;
        for (int i = 0; i < NUM_OBJS; i++) begin
            r       = '0;
            r.bank  = model_bank;
            r.idx   = i[3:0];
            r.ld1n  = 1'b1; r.ld2n = 1'b1; r.cl1n = 1'b1; r.cl2n = 1'b1;
            r.busy  = 1'b1;
            r.fetch = 1'b1;
            if (i == 0) begin
                r.ovr = ovr;
                if (model_bank) r.cl1n = 1'b0;
                else            r.cl2n = 1'b0;
            end
            sb.push_back(r);
            r.fetch = 1'b0; r.ovr = 1'b0; r.cl1n = 1'b1; r.cl2n = 1'b1;
            sb.push_back(r);
            if (hits[i]) begin
                if (model_bank) r.ld2n = 1'b0;
                else            r.ld1n = 1'b0;
                sb.push_back(r);
                r.ld1n = 1'b1; r.ld2n = 1'b1;
                for (int k = 0; k < PIX_W; k++) begin
                    r.wr_en = 1'b1;
                    r.addr  = 8'(cur_x[i] + k);
                    sb.push_back(r);
                end
                r.wr_en = 1'b0; r.addr = 8'h00;
            end
            sb.push_back(r);
        end
        r.busy = 1'b0;
        sb.push_back(r);
    endtask

    // Pending expectations at a new line_start mean the old line is cut off.
    task automatic start_line(input logic [15:0] hits);
        logic ovr;
        @(negedge CLK5n); #1;
        ovr = (sb.size() != 0);
        sb.delete();
        cur_hits = hits;
        for (int i = 0; i < NUM_OBJS; i++) cur_x[i] = next_x[i];
        push_line(hits, ovr);
        bus.line_start = 1'b1;
        @(negedge CLK5n); #1;
        bus.line_start = 1'b0;
    endtask

    // Start a line; the next line_start then lands 'gap' cycles later.
    task automatic line_gap(input logic [15:0] hits, input int gap);
        start_line(hits);
        repeat (gap - 2) @(negedge CLK5n);
    endtask

    task automatic check_reset_vals(input string name);
        logic [12:0] got;
        got = {bus.bank, bus.mo_index, bus.fetch, bus.LD1n, bus.LD2n,
               bus.CL1n, bus.CL2n, bus.wr_en, bus.busy, bus.overrun};
        checks++;
        if (got !== 13'b0_0000_0_1111_000) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, got, 13'b0_0000_0_1111_000);
        end
    endtask

    initial begin
        logic [15:0] h;
        int          gap;
        checks = 0; failures = 0;
        model_bank = 1'b0; idle_bank = 1'b0; idle_idx = 4'd0;
        cur_hits = 16'h0000; wcnt = 8'h00;
        for (int i = 0; i < NUM_OBJS; i++) begin
            cur_x[i] = 8'h00; next_x[i] = 8'h00;
        end
        RESET = 1'b1;
        bus.line_start = 1'b0;
        #3;
        check_reset_vals("reset_state");
        repeat (3) @(negedge CLK5n);
        #2 RESET = 1'b0;
        repeat (4) @(negedge CLK5n);

        // All miss; next line_start lands exactly in the DONE cycle.
        line_gap(16'h0000, 49);
        // Object 5 hits at x=0x40.
        next_x[5] = 8'h40;
        line_gap(16'h0020, 60);
        // Object 3 hits at x=0xFC: addresses wrap through 0x00.
        next_x[3] = 8'hFC;
        line_gap(16'h0008, 62);
        // All objects hit; the next line arrives after 100 cycles (overrun).
        for (int i = 0; i < NUM_OBJS; i++) next_x[i] = 8'($urandom);
        line_gap(16'hFFFF, 100);
        line_gap(16'h0000, 60);

        // Reset in the first DRAW cycle of object 0.
        next_x[0] = 8'h10;
        start_line(16'h0001);
        repeat (3) @(negedge CLK5n);
        #2 RESET = 1'b1;
        #1 check_reset_vals("reset_mid_draw");
        sb.delete();
        model_bank = 1'b0; idle_bank = 1'b0; idle_idx = 4'd0;
        @(negedge CLK5n);
        #2 RESET = 1'b0;
        repeat (6) @(negedge CLK5n);

        // Randomised lines: mostly complete, some cut short.
        for (int n = 0; n < 24; n++) begin
            h = 16'($urandom) & 16'($urandom);
            for (int i = 0; i < NUM_OBJS; i++) next_x[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) gap = int'($urandom_range(2, 120));
            else gap = 49 + $countones(h) * (PIX_W + 1) + int'($urandom_range(0, 4));
            line_gap(h, gap);
        end

        for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge CLK5n);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        repeat (3) @(negedge CLK5n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
